sram_ctrl: RTL and testbench
============================

# sram_ctrl

Initiator-side controller for the single-port synchronous SRAM (8-bit address, 32-bit data). It drives the SRAM's `WE`/`addr`/`data_in` pins and consumes its `data_out`. It arbitrates CPU-side single-word read/write requests with a valid/ready handshake. It also contains a built-in self-test (BIST) engine that writes the mirrored two-bit pattern and reads it back for checking. The controller sits between the CPU load/store path and the SRAM instance in the parent.

## Interface
- `ADDR_W`, 8, SRAM address width.
- `DATA_W`, 32, SRAM data width; the pattern function requires 32.
- `DEPTH`, 32, number of words covered by BIST (addresses 0..DEPTH-1); must be ≤ 2^ADDR_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `res` in 1: synchronous, active-high reset.
- `req_valid` in 1: CPU request valid.
- `req_ready` out 1: high only in IDLE when `bist_start`=0 and `res`=0.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle read-data strobe; no backpressure.
- `rsp_rdata` out DATA_W: read data, held until the next response.
- `bist_start` in 1: sampled only in IDLE.
- `bist_busy` out 1: high in every BIST state, including DONE.
- `bist_done` out 1: one-cycle pulse at end of BIST.
- `bist_fail` out 1: sticky until the next accepted `bist_start` or reset.
- `bist_fail_addr` out ADDR_W: first failing address.
- `sram_we` out 1, `sram_addr` out ADDR_W, `sram_wdata` out DATA_W: to SRAM `WE`/`addr`/`data_in`.
- `sram_rdata` in DATA_W: from SRAM `data_out`.

## Operation
- SRAM contract:
  - Write occurs at the rising edge when `WE`=1.
  - Read is registered: `data_out` equals mem[addr] in the cycle after `addr` is presented with `WE`=0.
- All SRAM-side and response outputs are registered.
- FSM states: IDLE, WR, RD_ADDR, RD_DATA, B_WR, B_RD_ADDR, B_RD_CHK, DONE.
- IDLE:
  - `bist_start`=1 has priority over `req_valid`. Clear `bist_fail` and `bist_fail_addr`, go to B_WR with index 0.
  - Otherwise, `req_valid`&&`req_ready` latches the request. Go to WR if `req_we`=1, else RD_ADDR.
- WR: `sram_we`=1, `sram_addr`/`sram_wdata` = latched values for exactly one cycle, then IDLE. No response is generated for writes.
- RD_ADDR: `sram_we`=0, `sram_addr` = latched address, then RD_DATA.
- RD_DATA: capture `sram_rdata` into `rsp_rdata`. Assert `rsp_valid` the next cycle, which is back in IDLE.
- Pattern p(a), with i = a[4:0]:
  - If i ≤ 15, set bits 15−i and 15+i.
  - Else set bits i−15 and 46−i.
  - All other bits are 0.
- B_WR:
  - One write per cycle, `sram_addr`=index, `sram_wdata`=p(index).
  - After index DEPTH−1, reset index to 0 and go to B_RD_ADDR.
- B_RD_ADDR: drive index with `sram_we`=0, then B_RD_CHK.
- B_RD_CHK: compare `sram_rdata` with p(index).
  - On mismatch: `bist_fail`←1, `bist_fail_addr`←index, go to DONE.
  - On match with index=DEPTH−1: go to DONE.
  - Otherwise: index+1, go to B_RD_ADDR.
- DONE: `bist_done`=1 for one cycle, then IDLE.
- In IDLE, `sram_we`=0; `sram_addr`/`sram_wdata` hold their last values.

## Timing
- Reset: while `res`=1 and in the first cycle after it, every registered output is 0 and state is IDLE. `req_ready`=0 while `res`=1.
- Reset mid-operation aborts the access or BIST:
  - `sram_we` is 0 from the first edge with `res`=1.
  - No `rsp_valid` or `bist_done` for the aborted operation.
- Write: accepted at cycle N; `sram_we`=1 in N+1; `req_ready`=1 again in N+2.
- Read: accepted at N; address on SRAM in N+1; data captured at end of N+2; `rsp_valid` in N+3, with `req_ready`=1 in the same cycle.
- BIST, start accepted at cycle 0:
  - Writes occur in cycles 1..DEPTH.
  - Address k: RD_ADDR in cycle DEPTH+1+2k, CHK in cycle DEPTH+2+2k.
  - DONE follows the last CHK.
  - A full pass with DEPTH=32 puts DONE at cycle 97.
- A request presented during BIST stalls (`req_ready`=0) until IDLE.
- `req_addr` is used unmodified; no wrap logic is needed beyond ADDR_W.

## Structure
- Shared package `sram_pkg`: ADDR_W/DATA_W defaults, state enum, and pattern function `bist_pattern(addr)`.
- No sub-module. Single FSM with a BIST index counter; the SRAM is instantiated by the parent.

## Test plan
- Reset: hold `res` 2 cycles with `req_valid`=1 → all outputs 0, `req_ready`=0, no SRAM write. One cycle after release, `req_ready`=1.
- Write then read: write 0xDEADBEEF @0x05, then read @0x05 → `sram_we`=1 for exactly one cycle with addr 5. `rsp_valid` 3 cycles after read acceptance with `rsp_rdata`=0xDEADBEEF.
- BIST pass (DEPTH=32):
  - Write data is 0x00008000 @0, 0x00014000 @1, 0x40000002 @16, 0x00018000 @31.
  - `bist_done` at cycle 97, `bist_fail`=0, `bist_busy` high cycles 1..97.
- BIST fail: SRAM model flips bit 0 on reads of addr 16 → `bist_fail`=1, `bist_fail_addr`=16, CHK at cycle 66, `bist_done` at cycle 67. No reads occur past addr 16.
- Arbitration: `bist_start` and `req_valid` (read @0x03) in the same IDLE cycle → BIST runs, `req_ready`=0 throughout. The request is accepted the cycle after DONE; `rsp_valid` follows 3 cycles later.
- Reset mid-BIST at cycle 40 → `sram_we`=0 next cycle, no `bist_done`, `bist_busy`=0. A subsequent `bist_start` completes normally.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM initiator: default widths, FSM states and
// the BIST data pattern.
package sram_pkg;

  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_DATA_W = 32;
  localparam int BIST_DEPTH  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ADDR,
    S_RD_DATA,
    S_B_WR,
    S_B_RD_ADDR,
    S_B_RD_CHK,
    S_DONE
  } state_e;

  // Mirrored two-bit pattern keyed on the low five address bits. Bit indices
  // are computed mod 32, so 46-i becomes 14-i for the upper half.
  function automatic logic [31:0] bist_pattern(input logic [4:0] a5);
    logic [31:0] p;
    logic [4:0]  lo;
    logic [4:0]  hi;
    p = '0;
    if (a5 <= 5'd15) begin
      lo = 5'd15 - a5;
      hi = 5'd15 + a5;
    end else begin
      lo = a5 - 5'd15;
      hi = 5'd14 - a5;
    end
    p[lo] = 1'b1;
    p[hi] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// CPU-side controller for a single-port registered-read SRAM, with a BIST
// engine that writes bist_pattern() to every word and reads it back.
// All SRAM-side and response outputs are registered from next-state values
// so they line up with the state the FSM enters.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W = sram_pkg::SRAM_ADDR_W,
  parameter int DATA_W = sram_pkg::SRAM_DATA_W,
  parameter int DEPTH  = sram_pkg::BIST_DEPTH
) (
  input  logic              clk,
  input  logic              res,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_W-1:0] bist_fail_addr,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, idx_inc;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;

  assign idx_inc   = idx_q + 1'b1;
  assign req_ready = (state_q == S_IDLE) && !bist_start && !res;
  assign bist_busy = state_q inside {S_B_WR, S_B_RD_ADDR, S_B_RD_CHK, S_DONE};

  assign sram_we        = we_q;
  assign sram_addr      = addr_q;
  assign sram_wdata     = wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign bist_done      = done_q;
  assign bist_fail      = fail_q;
  assign bist_fail_addr = fail_addr_q;

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    done_d      = 1'b0;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    case (state_q)
      S_IDLE: begin
        if (bist_start) begin
          // BIST wins over a coincident CPU request.
          fail_d      = 1'b0;
          fail_addr_d = '0;
          idx_d       = '0;
          we_d        = 1'b1;
          addr_d      = '0;
          wdata_d     = DATA_W'(bist_pattern(5'd0));
          state_d     = S_B_WR;
        end else if (req_valid && req_ready) begin
          addr_d = req_addr;
          if (req_we) begin
            we_d    = 1'b1;
            wdata_d = req_wdata;
            state_d = S_WR;
          end else begin
            state_d = S_RD_ADDR;
          end
        end
      end
      S_WR:      state_d = S_IDLE;
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: begin
        rsp_rdata_d = sram_rdata;
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_B_WR: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          addr_d  = '0;
          state_d = S_B_RD_ADDR;
        end else begin
          idx_d   = idx_inc;
          we_d    = 1'b1;
          addr_d  = idx_inc;
          wdata_d = DATA_W'(bist_pattern(idx_inc[4:0]));
        end
      end
      S_B_RD_ADDR: state_d = S_B_RD_CHK;
      S_B_RD_CHK: begin
        if (sram_rdata != DATA_W'(bist_pattern(idx_q[4:0]))) begin
          fail_d      = 1'b1;
          fail_addr_d = idx_q;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_inc;
          addr_d  = idx_inc;
          state_d = S_B_RD_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access or BIST in flight.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural registered-read SRAM.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        res;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        bist_start, bist_busy, bist_done, bist_fail;
  logic [7:0]  bist_fail_addr;
  logic        sram_we;
  logic [7:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  sram_ctrl dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_fail(bist_fail), .bist_fail_addr(bist_fail_addr),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model; inj flips bit 0 on reads of address 16.
  logic [31:0] mem [256];
  logic        inj = 1'b0;
  int          wr_total = 0;
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (sram_we) begin
      mem[sram_addr] <= sram_wdata;
      wr_total       <= wr_total + 1;
    end
    sram_rdata <= mem[sram_addr] ^ ((inj && sram_addr == 8'd16) ? 32'h1 : 32'h0);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    chk("wr_ready_before", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("wr_we_n1", sram_we, 1);
    chk("wr_addr_n1", sram_addr, a);
    chk("wr_data_n1", sram_wdata, d);
    chk("wr_ready_n1", req_ready, 0);
    step();
    chk("wr_we_n2", sram_we, 0);
    chk("wr_ready_n2", req_ready, 1);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    step();
    req_valid = 1'b0;
    chk("rd_addr_n1", sram_addr, a);
    chk("rd_we_n1", sram_we, 0);
    step();
    chk("rd_rsp_n2", rsp_valid, 0);
    step();
    chk("rd_rsp_n3", rsp_valid, 1);
    chk("rd_data_n3", rsp_rdata, exp);
    chk("rd_ready_n3", req_ready, 1);
    step();
    chk("rd_rsp_n4", rsp_valid, 0);
    chk("rd_hold_n4", rsp_rdata, exp);
  endtask

  // Observations collected by run_bist.
  int          done_cyc, done_cnt, wr_cnt, wr_first, wr_last, max_rd;
  int          acc_cyc, rsp_first;
  logic [31:0] rsp_data;
  logic        busy_err, ready_err, fail_c1, we_rst, busy_rst;
  logic [31:0] wlog [256];
  int          rd_first [256];

  // Start BIST in cycle 0 and watch cycles 1..ncyc. Optionally present a
  // read request alongside bist_start and assert reset at cycle rst_at.
  task automatic run_bist(input int ncyc, input int rst_at, input logic with_req,
                          input logic [7:0] raddr);
    done_cyc = -1; done_cnt = 0; wr_cnt = 0; wr_first = -1; wr_last = -1;
    max_rd = -1; acc_cyc = -1; rsp_first = -1; rsp_data = '0;
    busy_err = 1'b0; ready_err = 1'b0; fail_c1 = 1'b1; we_rst = 1'b1; busy_rst = 1'b1;
    for (int i = 0; i < 256; i++) begin wlog[i] = '0; rd_first[i] = -1; end
    bist_start = 1'b1;
    if (with_req) begin req_valid = 1'b1; req_we = 1'b0; req_addr = raddr; end
    for (int c = 1; c <= ncyc; c++) begin
      step();
      bist_start = 1'b0;
      if (acc_cyc >= 0) req_valid = 1'b0;
      if (c == 1) fail_c1 = bist_fail;
      if (c == rst_at + 1) begin we_rst = sram_we; busy_rst = bist_busy; end
      if (rst_at < 0 && bist_busy != (c <= done_cyc || done_cyc < 0)) busy_err = 1'b1;
      if (bist_busy && req_ready) ready_err = 1'b1;
      if (bist_done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (sram_we && bist_busy) begin
        wr_cnt++;
        if (wr_first < 0) wr_first = c;
        wr_last = c;
        wlog[sram_addr] = sram_wdata;
      end
      if (!sram_we && bist_busy && c > 32) begin
        if (rd_first[sram_addr] < 0) rd_first[sram_addr] = c;
        if (int'(sram_addr) > max_rd) max_rd = int'(sram_addr);
      end
      if (rsp_valid && rsp_first < 0) begin rsp_first = c; rsp_data = rsp_rdata; end
      if (req_valid && req_ready && acc_cyc < 0) acc_cyc = c;
      if (c == rst_at) res = 1'b1;
      if (c == rst_at + 2) res = 1'b0;
    end
  endtask

  initial begin
    res = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h05;
    req_wdata = 32'hCAFEF00D; bist_start = 1'b0;

    // Reset held two cycles with a write request pending.
    step();
    chk("rst_ready_c1", req_ready, 0);
    chk("rst_we_c1", sram_we, 0);
    step();
    chk("rst_ready_c2", req_ready, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_rsp", {rsp_valid, rsp_rdata}, 0);
    chk("rst_bist", {bist_busy, bist_done, bist_fail, bist_fail_addr}, 0);
    chk("rst_no_write", wr_total, 0);
    res = 1'b0; req_valid = 1'b0;
    step();
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_we", sram_we, 0);

    // CPU writes then reads, including the top address.
    do_write(8'h05, 32'hDEADBEEF);
    do_write(8'hFF, 32'hA5A50F0F);
    do_write(8'h00, 32'hFFFFFFFF);
    chk("cpu_write_count", wr_total, 3);
    do_read(8'h05, 32'hDEADBEEF);
    do_read(8'hFF, 32'hA5A50F0F);
    do_read(8'h00, 32'hFFFFFFFF);

    // Full passing BIST.
    run_bist(100, -1, 1'b0, 8'h00);
    chk("pass_done_cyc", done_cyc, 97);
    chk("pass_done_cnt", done_cnt, 1);
    chk("pass_busy_window", busy_err, 0);
    chk("pass_wr_cnt", wr_cnt, 32);
    chk("pass_wr_first", wr_first, 1);
    chk("pass_wr_last", wr_last, 32);
    chk("pat_0", wlog[0], 32'h00008000);
    chk("pat_1", wlog[1], 32'h00014000);
    chk("pat_16", wlog[16], 32'h40000002);
    chk("pat_31", wlog[31], 32'h00018000);
    chk("pass_rd0_cyc", rd_first[0], 33);
    chk("pass_rd31_cyc", rd_first[31], 95);
    chk("pass_fail", bist_fail, 0);
    chk("pass_idle_busy", bist_busy, 0);

    // BIST with a corrupted read at address 16.
    inj = 1'b1;
    run_bist(75, -1, 1'b0, 8'h00);
    inj = 1'b0;
    chk("fail_done_cyc", done_cyc, 67);
    chk("fail_rd16_cyc", rd_first[16], 65);
    chk("fail_max_rd", max_rd, 16);
    chk("fail_flag", bist_fail, 1);
    chk("fail_addr", bist_fail_addr, 16);
    step();
    chk("fail_sticky", bist_fail, 1);

    // bist_start and a read request in the same IDLE cycle.
    run_bist(105, -1, 1'b1, 8'h03);
    chk("arb_fail_cleared", fail_c1, 0);
    chk("arb_done_cyc", done_cyc, 97);
    chk("arb_ready_during_bist", ready_err, 0);
    chk("arb_accept_cyc", acc_cyc, 98);
    chk("arb_rsp_cyc", rsp_first, 101);
    chk("arb_rsp_data", rsp_data, 32'h00041000);

    // Reset at cycle 40 of a BIST, then a clean BIST.
    run_bist(110, 40, 1'b0, 8'h00);
    chk("rst_mid_we", we_rst, 0);
    chk("rst_mid_busy", busy_rst, 0);
    chk("rst_mid_no_done", done_cnt, 0);
    run_bist(100, -1, 1'b0, 8'h00);
    chk("rerun_done_cyc", done_cyc, 97);
    chk("rerun_fail", bist_fail, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
